// File: rtl/action_decoder_if.sv
// Button-to-action request bundle: raw switch levels in, one-at-a-time action offers out.
// master is the decoder side, slave is the switch/consumer side.
interface action_decoder_if;
  logic [7:0] buttons;
  logic       action_ready;
  logic       action_valid;
  logic [2:0] action_code;
  logic [5:0] pressed;
  logic       busy;
  logic [7:0] dropped;

  modport master (
    input  buttons, action_ready,
    output action_valid, action_code, pressed, busy, dropped
  );

  modport slave (
    output buttons, action_ready,
    input  action_valid, action_code, pressed, busy, dropped
  );
endinterface

// File: rtl/action_decoder.sv
// Sync+debounce+edge-detect six buttons, latch presses, offer lowest pending over valid/ready (held until ready).
// Press-to-valid: 2+DEBOUNCE_CYCLES to pressed, +2 to valid; ACTION_COOLDOWN_EN adds a post-accept cooldown that drops presses.
module action_decoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  action_decoder_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_COOL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  sync1_q, sync2_q;
  logic [15:0] db_cnt_q [6];
  logic [15:0] db_cnt_d [6];
  logic [5:0]  pressed_q, pressed_d;
  logic [5:0]  pressed_prev_q;
  logic [5:0]  pending_q, pending_d;
  logic [5:0]  pend_set, pend_clr;
  logic [5:0]  rise;
  logic [2:0]  sel_code;
  logic        valid_q, valid_d;
  logic [2:0]  code_q, code_d;
  logic        busy_q, busy_d;
  logic [7:0]  dropped_q, dropped_d;
  logic        unused_hi_buttons;

  assign unused_hi_buttons = ^bus.buttons[7:6];

`ifdef ACTION_COOLDOWN_EN
  logic [23:0] cool_q, cool_d;
  logic [8:0]  drop_sum;

  assign drop_sum = {1'b0, dropped_q} + 9'($countones(rise));
`else
  logic [23:0] unused_cooldown;

  assign unused_cooldown = COOLDOWN_CYCLES;
`endif

  // A level only flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < 6; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != pressed_q[i]) begin
        if (db_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign rise = pressed_q & ~pressed_prev_q;

  always_comb begin
    sel_code = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_code = 3'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    code_d    = code_q;
    pend_set  = rise;
    pend_clr  = '0;
    dropped_d = dropped_q;
`ifdef ACTION_COOLDOWN_EN
    cool_d    = cool_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = S_OFFER;
          valid_d = 1'b1;
          code_d  = sel_code;
        end
      end
      S_OFFER: begin
        // A same-cycle re-press of the offered bit is set then cleared, i.e. merged.
        if (bus.action_ready) begin
          pend_clr = 6'b000001 << (code_q - 3'd1);
          valid_d  = 1'b0;
          code_d   = 3'd0;
`ifdef ACTION_COOLDOWN_EN
          state_d  = S_COOL;
          cool_d   = COOLDOWN_CYCLES - 24'd1;
`else
          state_d  = S_IDLE;
`endif
        end
      end
`ifdef ACTION_COOLDOWN_EN
      S_COOL: begin
        pend_set  = '0;
        dropped_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        if (cool_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cool_d = cool_q - 24'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    pending_d = (pending_q | pend_set) & ~pend_clr;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sync1_q        <= '0;
      sync2_q        <= '0;
      pressed_q      <= '0;
      pressed_prev_q <= '0;
      pending_q      <= '0;
      valid_q        <= 1'b0;
      code_q         <= 3'd0;
      busy_q         <= 1'b0;
      dropped_q      <= '0;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sync1_q        <= bus.buttons[5:0];
      sync2_q        <= sync1_q;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_q;
      pending_q      <= pending_d;
      valid_q        <= valid_d;
      code_q         <= code_d;
      busy_q         <= busy_d;
      dropped_q      <= dropped_d;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

`ifdef ACTION_COOLDOWN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cool_q <= '0;
    end else begin
      cool_q <= cool_d;
    end
  end
`endif

  assign bus.action_valid = valid_q;
  assign bus.action_code  = code_q;
  assign bus.pressed      = pressed_q;
  assign bus.busy         = busy_q;
  assign bus.dropped      = dropped_q;

endmodule

// File: tb/tb_action_decoder.sv
// Bench for action_decoder: vector table, hand-written corner sequences and random stimulus vs a reference model.
module tb_action_decoder;
  localparam int DB = 4;
  localparam int CD = 8;
`ifdef ACTION_COOLDOWN_EN
  localparam bit COOL_EN = 1'b1;
`else
  localparam bit COOL_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  action_decoder_if bus ();

  action_decoder #(
    .DEBOUNCE_CYCLES(16'(DB)),
    .COOLDOWN_CYCLES(24'(CD))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hs_codes[$];
  int hs_cyc[$];

  // Reference model: spec rules over plain variables.
  logic [5:0] m_s1, m_s2, m_pressed, m_prev;
  int m_run[6];
  bit m_pend[6];
  int m_offer;   // offered button index, -1 when nothing is offered
  int m_cool;    // cooldown cycles left, -1 when not cooling
  int m_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_pressed = '0; m_prev = '0;
    for (int i = 0; i < 6; i++) begin
      m_run[i] = 0;
      m_pend[i] = 1'b0;
    end
    m_offer = -1;
    m_cool  = -1;
    m_drop  = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic r);
    bit rise[6];
    int low;
    logic [5:0] np;
    low = -1;
    for (int i = 0; i < 6; i++) begin
      rise[i] = m_pressed[i] && !m_prev[i];
      if (m_pend[i] && low < 0) low = i;
    end
    np = m_pressed;
    for (int i = 0; i < 6; i++) begin
      if (m_s2[i] == m_pressed[i]) m_run[i] = 0;
      else if (m_run[i] == DB - 1) begin
        np[i] = ~np[i];
        m_run[i] = 0;
      end else m_run[i]++;
    end
    m_prev = m_pressed;
    m_pressed = np;
    m_s2 = m_s1;
    m_s1 = b[5:0];
    if (m_cool >= 0) begin
      for (int i = 0; i < 6; i++)
        if (rise[i] && m_drop < 255) m_drop++;
      m_cool = (m_cool == 0) ? -1 : m_cool - 1;
    end else begin
      for (int i = 0; i < 6; i++)
        if (rise[i]) m_pend[i] = 1'b1;
      if (m_offer >= 0) begin
        if (r) begin
          m_pend[m_offer] = 1'b0;
          m_offer = -1;
          if (COOL_EN) m_cool = CD - 1;
        end
      end else if (low >= 0) begin
        m_offer = low;
      end
    end
  endtask

  task automatic check_model();
    chk("model_pressed", int'(bus.pressed), int'(m_pressed));
    chk("model_valid", int'(bus.action_valid), (m_offer >= 0) ? 1 : 0);
    chk("model_code", int'(bus.action_code), (m_offer >= 0) ? m_offer + 1 : 0);
    chk("model_busy", int'(bus.busy), (m_offer >= 0 || m_cool >= 0) ? 1 : 0);
    chk("model_dropped", int'(bus.dropped), m_drop);
  endtask

  task automatic tick();
    if (bus.action_valid && bus.action_ready) begin
      hs_codes.push_back(int'(bus.action_code));
      hs_cyc.push_back(cyc);
    end
    if (reset) model_reset();
    else model_step(bus.buttons, bus.action_ready);
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.buttons = 8'h00;
    bus.action_ready = 1'b0;
    ticks(2);
    reset = 1'b0;
    hs_codes.delete();
    hs_cyc.delete();
  endtask

  task automatic wait_valid(input string name, input int bound);
    int k;
    k = 0;
    while (!bus.action_valid && k < bound) begin
      tick();
      k++;
    end
    chk(name, int'(bus.action_valid), 1);
  endtask

  typedef struct {
    logic [7:0] mask;
    int n;
    int first;
    int last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, c0, c1, gap, fives;

    vecs[0] = '{8'h01, 1, 1, 1};
    vecs[1] = '{8'h0A, 2, 2, 4};
    vecs[2] = '{8'hC0, 0, 0, 0};
    vecs[3] = '{8'h20, 1, 6, 6};
    vecs[4] = '{8'h3F, 6, 1, 6};
    vecs[5] = '{8'h44, 1, 3, 3};
    vecs[6] = '{8'h11, 2, 1, 5};

    reset = 1'b1;
    bus.buttons = 8'h00;
    bus.action_ready = 1'b0;
    model_reset();
    do_reset();
    chk("reset_valid", int'(bus.action_valid), 0);
    chk("reset_code", int'(bus.action_code), 0);
    chk("reset_dropped", int'(bus.dropped), 0);

    // Vector table: hold a button mask with ready high, count accepted offers.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      bus.action_ready = 1'b1;
      bus.buttons = vecs[v].mask;
      ticks(120);
      bus.buttons = 8'h00;
      ticks(20);
      chk($sformatf("vec%0d_count", v), hs_codes.size(), vecs[v].n);
      chk($sformatf("vec%0d_first", v), (hs_codes.size() > 0) ? hs_codes[0] : 0, vecs[v].first);
      chk($sformatf("vec%0d_last", v), (hs_codes.size() > 0) ? hs_codes[hs_codes.size()-1] : 0, vecs[v].last);
    end

    // Bounce rejection.
    do_reset();
    bus.action_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      bus.buttons = (p % 2 == 0) ? 8'h01 : 8'h00;
      ticks(2);
    end
    bus.buttons = 8'h01;
    n = 0;
    while (!bus.pressed[0] && n < 20) begin
      tick();
      n++;
    end
    chk("bounce_press_latency", n, 2 + DB);
    ticks(30);
    chk("bounce_offer_count", hs_codes.size(), 1);
    chk("bounce_offer_code", (hs_codes.size() > 0) ? hs_codes[0] : 0, 1);

    // Simultaneous press of buttons 3 and 1.
    do_reset();
    bus.action_ready = 1'b1;
    bus.buttons = 8'h0A;
    ticks(40);
    c0 = (hs_codes.size() > 0) ? hs_codes[0] : 0;
    c1 = (hs_codes.size() > 1) ? hs_codes[1] : 0;
    gap = (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : 0;
    chk("simul_count", hs_codes.size(), 2);
    chk("simul_first_code", c0, 2);
    chk("simul_second_code", c1, 4);
    chk("simul_accept_gap", gap, COOL_EN ? CD + 2 : 2);

    // Backpressure: offer held stable while ready is low.
    do_reset();
    bus.buttons = 8'h04;
    wait_valid("bp_valid_rise", 30);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid_held", int'(bus.action_valid), 1);
      chk("bp_code_held", int'(bus.action_code), 3);
    end
    bus.action_ready = 1'b1;
    tick();
    chk("bp_valid_drop", int'(bus.action_valid), 0);
    chk("bp_one_accept", hs_codes.size(), 1);
    bus.buttons = 8'h00;
    ticks(20);

`ifdef ACTION_COOLDOWN_EN
    // Press during cooldown is dropped.
    do_reset();
    bus.action_ready = 1'b1;
    bus.buttons = 8'h01;
    n = 0;
    while (hs_codes.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    chk("cool_first_accept", hs_codes.size(), 1);
    bus.buttons = 8'h11;
    ticks(40);
    fives = 0;
    foreach (hs_codes[i]) if (hs_codes[i] == 5) fives++;
    chk("cool_dropped", int'(bus.dropped), 1);
    chk("cool_no_code5", fives, 0);
    bus.buttons = 8'h00;
    ticks(20);
`else
    // Two separate presses of button 5 both get through.
    do_reset();
    bus.action_ready = 1'b1;
    bus.buttons = 8'h20; ticks(5);
    bus.buttons = 8'h00; ticks(5);
    bus.buttons = 8'h20; ticks(5);
    bus.buttons = 8'h00; ticks(30);
    chk("nocool_count", hs_codes.size(), 2);
    chk("nocool_code_a", (hs_codes.size() > 0) ? hs_codes[0] : 0, 6);
    chk("nocool_code_b", (hs_codes.size() > 1) ? hs_codes[1] : 0, 6);
    chk("nocool_dropped", int'(bus.dropped), 0);
`endif

    // Asynchronous reset in the middle of an offer.
    do_reset();
    bus.buttons = 8'h05;
    wait_valid("rst_valid_rise", 30);
    chk("rst_offer_code", int'(bus.action_code), 1);
    ticks(2);
    #3;
    reset = 1'b1;
    bus.buttons = 8'h00;
    #1;
    model_reset();
    chk("rst_async_valid", int'(bus.action_valid), 0);
    chk("rst_async_code", int'(bus.action_code), 0);
    chk("rst_async_pressed", int'(bus.pressed), 0);
    chk("rst_async_busy", int'(bus.busy), 0);
    chk("rst_async_dropped", int'(bus.dropped), 0);
    ticks(2);
    reset = 1'b0;
    hs_codes.delete();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.action_valid) n++;
    end
    chk("rst_no_offer_cycles", n, 0);

    // Random buttons and ready against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) bus.buttons = 8'($urandom);
      bus.action_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/action_decoder.md
# action_decoder

Input-side front end for the pet core: turns raw push-button levels from the dedicated input switches into clean, one-at-a-time action requests for the stats block. It sits between `ui_in` and `stats`, the opposite end of the path that carries `status` out to the LEDs. Each raw line is synchronized, debounced, edge-detected and latched. One pending request is offered at a time over a valid/ready handshake, with an optional cooldown between accepted actions.

## Interface
- `DEBOUNCE_CYCLES`, 16'd50_000: consecutive stable cycles required before a debounced level changes.
- `COOLDOWN_CYCLES`, 24'd10_000_000: cycles new presses are ignored after an accepted action (only with `ACTION_COOLDOWN_EN`).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `buttons` in 8: raw button levels, active high.
  - Bits [5:0] map to feed, play, heal, clean, sleep and talk.
  - Bits [7:6] are ignored.
- `action_ready` in 1: consumer accepts `action_code` this cycle.
- `action_valid` out 1: an action is offered.
- `action_code` out 3: 0 = none, 1..6 = button index + 1.
- `pressed` out 6: debounced button levels.
- `busy` out 1: high in OFFER or COOL.
- `dropped` out 8: saturating count of discarded presses.

## Operation
- **Synchronizer:** two flops per bit, bits [5:0].
- **Debounce:** one counter per bit.
  - The counter resets to 0 whenever the synced level equals `pressed[i]`.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1`, `pressed[i]` toggles and the counter clears.
- **Edge detect:** a 0→1 transition of `pressed[i]` is a press. Releases generate nothing.
- **Press in IDLE or OFFER:** sets `pending[i]`. If `pending[i]` is already set, the press merges and the count is unchanged.
- **Press in COOL:** discarded; `dropped` increments and saturates at 255.
- **Simultaneous presses:** multiple bits may set pending in the same cycle.
- **FSM IDLE:** when `pending != 0`, select the lowest set index `k`, register `action_code = k+1`, assert `action_valid`, and go to OFFER.
- **FSM OFFER:** `action_valid` and `action_code` stay stable until `action_ready`.
  - On handshake, clear `pending[k]`.
  - Go to COOL and load the cooldown counter (macro on), or go to IDLE (macro off).
  - `action_valid` drops the cycle after the handshake.
  - Presses arriving in OFFER are latched. A new press of the offered bit `k` merges into the current offer.
- **FSM COOL:** the counter decrements to 0, then the FSM goes to IDLE. Pending bits latched earlier are preserved and offered afterward.
- **`action_ready` without `action_valid`:** ignored.
- **Reset (async, any state):**
  - FSM goes to IDLE.
  - Cleared to 0: `pending`, all counters, `pressed`, `action_valid`, `action_code`, `busy`, `dropped`.
  - Synchronizer flops are cleared to 0.

## Timing
- **Press latency:** a raw level change reaches `pressed` after 2 + `DEBOUNCE_CYCLES` cycles of stability.
- **Offer latency:**
  - `pressed` rising at cycle t sets `pending` at t+1.
  - From IDLE, `action_valid` is asserted at t+2.
- **Throughput:**
  - With the macro: at most one accepted action per `COOLDOWN_CYCLES` + 2 cycles.
  - Without the macro: with `action_ready` tied high, one action per 2 cycles (OFFER, IDLE).
- **Output registers:** all outputs are registered; no combinational path from `action_ready` to any output.

## Configuration
- **`ACTION_COOLDOWN_EN`** defined: the COOL state, cooldown counter and press-dropping are present.
- **`ACTION_COOLDOWN_EN`** undefined:
  - OFFER returns directly to IDLE.
  - No press is ever discarded, so `dropped` stays 0.
  - `busy` follows OFFER only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `COOLDOWN_CYCLES`=8.

1. **Bounce rejection:** toggle `buttons[0]` every 2 cycles for 20 cycles, then hold it high.
   - `pressed[0]` rises exactly 6 cycles after the final rise.
   - One offer appears with `action_code`=1.
2. **Simultaneous press:** raise `buttons[3]` and `buttons[1]` together, with `action_ready` high.
   - Code 2 is offered first.
   - After cooldown, code 4 is offered.
   - Each offer is held for exactly one handshake.
3. **Backpressure:** press `buttons[2]` with `action_ready` low for 10 cycles.
   - `action_valid`=1 and `action_code`=3 are held stable.
   - When ready rises, valid drops the next cycle.
4. **Press during COOL (macro on):** press `buttons[4]` during the cooldown window.
   - `dropped`=1.
   - No code-5 offer is made.
5. **Macro off:** with `action_ready` high, press `buttons[5]` twice, 10 cycles apart.
   - Two offers with code 6.
   - `dropped`=0.
6. **Reset in OFFER:** assert `reset` mid-OFFER with `pending`=6'b000101.
   - All outputs are 0 in the same cycle.
   - After release, no offer appears without a new press.
